// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Drives one DSP slice as a multiply-accumulate engine. A job of `len` signed 18x18 operand
// pairs arrives on a valid/ready stream. Each pair is pushed into the slice's A/B ports. The
// slice's opMode and clock enables are sequenced so that P accumulates the sum of products.
// The 48-bit P value is then returned on a valid/ready result port.
//
// Ports
//   clk, rstN                  clock, asynchronous active-low reset
//   start, len, busy           job request (sampled in idle), pair count, not-idle flag
//   op_valid/op_ready/op_a/b   operand pair stream
//   res_valid/res_ready/data   result stream; 48-bit accumulated sum
//   dsp_a, dsp_b               slice A/B inputs (combinational from op_a/op_b)
//   dsp_ce_a/b/m/opmode/p      slice clock enables
//   dsp_opmode                 slice opMode (registered inside the slice)
//   dsp_p                      slice P output
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_ce_a,
  output logic             dsp_ce_b,
  output logic             dsp_ce_m,
  output logic             dsp_ce_opmode,
  output logic             dsp_ce_p,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p
);

  localparam int unsigned Depth = MUL_LAT + 1;

  // X=M, Z=0 for the first product (overwrites stale P); X=M, Z=P afterwards.
  localparam logic [7:0] OpFirst = 8'h01;
  localparam logic [7:0] OpAcc   = 8'h09;
  localparam logic [7:0] OpNone  = 8'h00;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;
  logic [47:0]      res_data_q, res_data_d;

  // Tag pipe, bit i = stage i+1. The first flag is only consulted at stage MUL_LAT-1,
  // so its pipe stops there.
  logic [Depth-1:0]   vld_q;
  logic [Depth-1:0]   lst_q;
  logic [MUL_LAT-2:0] fst_q;

  logic op_hs;
  logic last_out;

  assign op_ready = (state_q == StRun);
  assign op_hs    = op_valid & op_ready;
  assign last_out = vld_q[Depth-1] & lst_q[Depth-1];

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            state_d     = StRun;
            remaining_d = len;
            first_d     = 1'b1;
          end else begin
            state_d    = StDone;
            res_data_d = '0;
          end
        end
      end
      StRun: begin
        if (op_hs) begin
          remaining_d = remaining_q - LEN_W'(1);
          first_d     = 1'b0;
          if (remaining_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // P has absorbed the last product by the time its tag leaves the pipe.
        if (last_out) begin
          res_data_d = dsp_p;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      first_q     <= 1'b0;
      res_data_q  <= '0;
      vld_q       <= '0;
      lst_q       <= '0;
      fst_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      res_data_q  <= res_data_d;
      // The pipe shifts every cycle; cycles without a handshake insert bubble tags.
      vld_q       <= Depth'({vld_q, op_hs});
      lst_q       <= Depth'({lst_q, op_hs & (remaining_q == LEN_W'(1))});
      fst_q       <= (MUL_LAT - 1)'({fst_q, op_hs & first_q});
    end
  end

  always_comb begin
    dsp_opmode = OpNone;
    if (vld_q[MUL_LAT-2]) dsp_opmode = fst_q[MUL_LAT-2] ? OpFirst : OpAcc;
  end

  assign busy          = (state_q != StIdle);
  assign res_valid     = (state_q == StDone);
  assign res_data      = res_data_q;
  assign dsp_a         = op_a;
  assign dsp_b         = op_b;
  assign dsp_ce_a      = op_hs;
  assign dsp_ce_b      = op_hs;
  assign dsp_ce_m      = 1'b1;
  assign dsp_ce_opmode = 1'b1;
  assign dsp_ce_p      = vld_q[MUL_LAT-1];

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Testbench for dsp_mac_sequencer. A behavioural DSP slice (A1, M, opMode and P registers)
// closes the loop. Expected sums are pushed to a queue when a job is issued and popped
// when the result handshake occurs.
module tb_dsp_mac_sequencer;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned MUL_LAT = 2;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [17:0]      op_a = '0;
  logic [17:0]      op_b = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [47:0]      res_data;
  logic [17:0]      dsp_a, dsp_b;
  logic             dsp_ce_a, dsp_ce_b, dsp_ce_m, dsp_ce_opmode, dsp_ce_p;
  logic [7:0]       dsp_opmode;
  logic [47:0]      dsp_p;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rstN(rstN), .start(start), .len(len), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ce_a(dsp_ce_a), .dsp_ce_b(dsp_ce_b),
    .dsp_ce_m(dsp_ce_m), .dsp_ce_opmode(dsp_ce_opmode), .dsp_ce_p(dsp_ce_p),
    .dsp_opmode(dsp_opmode), .dsp_p(dsp_p)
  );

  always #5 clk = ~clk;

  // Behavioural slice: A1REG=1, MREG=1, registered opMode, P register.
  logic signed [17:0] s_a1, s_b1;
  logic signed [35:0] s_m;
  logic [7:0]         s_opm;
  logic [47:0]        s_p;
  always @(posedge clk) begin
    if (dsp_ce_a) s_a1 <= dsp_a;
    if (dsp_ce_b) s_b1 <= dsp_b;
    if (dsp_ce_m) s_m <= s_a1 * s_b1;
    if (dsp_ce_opmode) s_opm <= dsp_opmode;
    if (dsp_ce_p)
      s_p <= ((s_opm[3:2] == 2'b10) ? s_p : 48'd0) +
             ((s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0);
  end
  assign dsp_p = s_p;

  // Cycle bookkeeping: cyc counts rising edges; histories are sampled on the falling edge.
  int         cyc = 0;
  int         ce_cnt = 0;
  logic [7:0] opm_hist [0:4095];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    opm_hist[cyc[11:0]] <= dsp_opmode;
    if (dsp_ce_p === 1'b1) ce_cnt <= ce_cnt + 1;
  end

  int          checks = 0;
  int          failures = 0;
  logic [47:0] exp_q [$];
  int          hs_log [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge with the DUT idle.
  task automatic start_job(input int n);
    start = 1'b1;
    len   = n[LEN_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b, input int gap);
    int   guard = 0;
    logic ok = 1'b0;
    op_valid = 1'b1;
    op_a     = a[17:0];
    op_b     = b[17:0];
    while (!ok && guard < 50) begin
      @(negedge clk);
      if (op_ready === 1'b1) ok = 1'b1;
      else guard++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL handshake: op_ready=%b required 1 within 50 cycles", op_ready);
    end else begin
      hs_log.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_result(input string name, input bit chk_lat);
    int          guard = 0;
    int          rise;
    logic [47:0] exp;
    do begin @(negedge clk); guard++; end while (res_valid !== 1'b1 && guard < 1000);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hX;
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s res_valid timeout: got %b required 1", name, res_valid);
      return;
    end
    rise = cyc;
    checks++;
    if (res_data !== exp) begin
      failures++;
      $display("FAIL %s res_data: got %0d (0x%h) required %0d (0x%h)", name, res_data, res_data,
               exp, exp);
    end
    if (chk_lat) begin
      checks++;
      if (rise - hs_log[$] != MUL_LAT + 1) begin
        failures++;
        $display("FAIL %s drain latency: got %0d required %0d", name, rise - hs_log[$],
                 MUL_LAT + 1);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s release: busy=%b res_valid=%b required 0 0", name, busy, res_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, op_ready, res_valid, dsp_ce_p, dsp_opmode, res_data} !== '0) begin
      failures++;
      $display("FAIL reset outputs: busy=%b op_ready=%b res_valid=%b ce_p=%b opmode=%h data=%h required all 0",
               busy, op_ready, res_valid, dsp_ce_p, dsp_opmode, res_data);
    end
    checks++;
    if (dsp_ce_m !== 1'b1 || dsp_ce_opmode !== 1'b1) begin
      failures++;
      $display("FAIL reset ce_m/ce_opmode: got %b %b required 1 1", dsp_ce_m, dsp_ce_opmode);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int c0;
    c0 = ce_cnt;
    hs_log.delete();
    exp_q.push_back(48'd19);
    start_job(3);
    send_pair(2, 3, 0);
    send_pair(4, 5, 0);
    send_pair(-1, 7, 0);
    wait_result("basic", 1'b1);
    checks++;
    if (ce_cnt - c0 != 3) begin
      failures++;
      $display("FAIL basic ce_p cycles: got %0d required 3", ce_cnt - c0);
    end
    checks++;
    if (hs_log.size() != 3 || hs_log[2] - hs_log[0] != 2) begin
      failures++;
      $display("FAIL basic back-to-back: handshakes=%0d span=%0d required 3 and 2",
               hs_log.size(), (hs_log.size() == 3) ? hs_log[2] - hs_log[0] : -1);
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] e;
    hs_log.delete();
    exp_q.push_back(48'd19);
    start_job(3);
    send_pair(2, 3, 2);
    send_pair(4, 5, 2);
    send_pair(-1, 7, 0);
    wait_result("bubbles", 1'b0);
    checks++;
    if (hs_log.size() != 3 || hs_log[1] - hs_log[0] != 3 || hs_log[2] - hs_log[1] != 3) begin
      failures++;
      $display("FAIL bubbles spacing: handshakes=%0d required 3 spaced by 3", hs_log.size());
    end else begin
      for (int k = hs_log[0]; k <= hs_log[2] + 1; k++) begin
        e = (k == hs_log[0]) ? 8'h01 : ((k == hs_log[1] || k == hs_log[2]) ? 8'h09 : 8'h00);
        checks++;
        if (opm_hist[k[11:0]] !== e) begin
          failures++;
          $display("FAIL bubbles opmode at cycle %0d: got %h required %h", k - hs_log[0],
                   opm_hist[k[11:0]], e);
        end
      end
    end
  endtask

  task automatic test_empty_then_one();
    exp_q.push_back(48'd0);
    start_job(0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 48'd0) begin
      failures++;
      $display("FAIL empty job: res_valid=%b res_data=%h required 1 0", res_valid, res_data);
    end
    wait_result("empty", 1'b0);
    exp_q.push_back(48'h4_0000_0000);
    start_job(1);
    send_pair(-131072, -131072, 0);
    wait_result("single_overwrite", 1'b0);
  endtask

  task automatic test_backpressure();
    int guard = 0;
    exp_q.push_back(48'd35);
    start_job(1);
    send_pair(5, 7, 0);
    while (res_valid !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 5; i++) begin
      start    = 1'b1;
      len      = 8'd5;
      op_valid = i[0];
      op_a     = 18'd9;
      op_b     = 18'd9;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 48'd35 || op_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL backpressure hold %0d: res_valid=%b data=%0d op_ready=%b busy=%b required 1 35 0 1",
                 i, res_valid, res_data, op_ready, busy);
      end
      @(posedge clk); #1;
    end
    start    = 1'b0;
    op_valid = 1'b0;
    wait_result("backpressure", 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure stray start: busy=%b required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    start_job(4);
    send_pair(100, 200, 0);
    send_pair(300, 400, 0);
    rstN = 1'b0;
    #1;
    checks++;
    if ({busy, op_ready, res_valid, dsp_ce_p, dsp_opmode, res_data} !== '0) begin
      failures++;
      $display("FAIL mid reset outputs: busy=%b op_ready=%b res_valid=%b ce_p=%b opmode=%h data=%h required all 0",
               busy, op_ready, res_valid, dsp_ce_p, dsp_opmode, res_data);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(48'd10);
    start_job(2);
    send_pair(3, 3, 0);
    send_pair(1, 1, 0);
    wait_result("after_reset", 1'b0);
  endtask

  task automatic test_wrap();
    longint w;
    w = 255 * (longint'(1) << 34);
    exp_q.push_back(w[47:0]);
    start_job(255);
    for (int i = 0; i < 255; i++) send_pair(-131072, -131072, 0);
    wait_result("wrap", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_empty_then_one();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
